// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage with an integrated program loader.
//   After reset the block sits in LOAD, assembling big-endian bytes from the
//   debug unit into 32-bit words and writing them to a local instruction
//   memory. On i_load_done it moves to RUN. In RUN it fetches the word at i_pc,
//   computes the next PC and fills the IF/ID register. Capturing HALT_WORD into
//   IF/ID moves it to HALTED, which only reset can leave.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_load_valid/_byte/_done      program byte stream from the debug unit
//   i_pc                          current PC from the PC stage
//   i_branch_taken/_target        resolved branch
//   i_jump/_target                jump request
//   i_stall, i_flush              hazard stall, IF/ID flush
//   o_next_pc, o_pc_stall, o_halt controls back to the PC stage
//   o_instr, o_pc_plus4, o_ifid_valid  IF/ID register
//   o_state, o_words_loaded, o_load_overflow  status
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
    localparam int         AW        = $clog2(MEM_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load_valid,
    input  logic [7:0]    i_load_byte,
    input  logic          i_load_done,
    input  logic [31:0]   i_pc,
    input  logic          i_branch_taken,
    input  logic [31:0]   i_branch_target,
    input  logic          i_jump,
    input  logic [31:0]   i_jump_target,
    input  logic          i_stall,
    input  logic          i_flush,
    output logic [31:0]   o_next_pc,
    output logic          o_pc_stall,
    output logic          o_halt,
    output logic [31:0]   o_instr,
    output logic [31:0]   o_pc_plus4,
    output logic          o_ifid_valid,
    output logic [1:0]    o_state,
    output logic [AW:0]   o_words_loaded,
    output logic          o_load_overflow
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(MEM_DEPTH);

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   byte_buf_q, byte_buf_d;   // first three bytes of the word in progress
    logic [AW:0]   words_q, words_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pc_plus4_q, pc_plus4_d;
    logic          valid_q, valid_d;

    logic [31:0]   mem_q [MEM_DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [31:0]   fetched;
    logic [31:0]   pc_plus4;
    logic          pc_in_range;
    logic          halt_capture;

    assign pc_plus4    = i_pc + 32'd4;
    // Anything at or beyond the end of memory reads as a NOP.
    assign pc_in_range = (i_pc >> (AW + 2)) == 32'd0;
    assign fetched     = pc_in_range ? mem_q[i_pc[AW+1:2]] : 32'h0;

    // A halt word only counts when it actually lands in IF/ID.
    assign halt_capture = (state_q == ST_RUN) && !i_stall && !i_flush &&
                          (fetched == HALT_WORD);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        byte_buf_d = byte_buf_q;
        words_d    = words_q;
        ovf_d      = ovf_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        mem_we     = 1'b0;
        mem_waddr  = words_q[AW-1:0];
        mem_wdata  = {byte_buf_q, i_load_byte};
        o_next_pc  = i_pc;
        o_pc_stall = i_stall;
        o_halt     = 1'b0;

        // Loader: the byte is consumed before any transition on load_done.
        if (state_q == ST_LOAD) begin
            o_pc_stall = 1'b1;
            if (i_load_valid) begin
                if (byte_cnt_q == 2'd3) begin
                    byte_cnt_d = 2'd0;
                    if (words_q == DEPTH_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        words_d = words_q + 1'b1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    byte_buf_d = {byte_buf_q[15:0], i_load_byte};
                end
            end
            if (i_load_done) begin
                state_d    = ST_RUN;
                byte_cnt_d = 2'd0;   // drop any partial word
            end
        end

        if (state_q == ST_RUN) begin
            o_next_pc = i_jump         ? i_jump_target   :
                        i_branch_taken ? i_branch_target : pc_plus4;
            o_halt    = halt_capture;
            if (halt_capture) state_d = ST_HALTED;
        end

        if (state_q == ST_HALTED) o_halt = 1'b1;

        // IF/ID: flush > stall > capture.
        if (i_flush) begin
            instr_d    = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (!i_stall) begin
            if (state_q == ST_RUN) begin
                instr_d    = fetched;
                pc_plus4_d = pc_plus4;
                valid_d    = 1'b1;
            end else begin
                instr_d    = 32'h0;
                pc_plus4_d = 32'h0;
                valid_d    = 1'b0;
            end
        end

        // Combinational outputs take their reset values while reset is held,
        // even before the first edge has settled the state register.
        if (i_rst) begin
            o_next_pc  = i_pc;
            o_pc_stall = 1'b1;
            o_halt     = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_LOAD;
            byte_cnt_q <= 2'd0;
            byte_buf_q <= 24'h0;
            words_q    <= '0;
            ovf_q      <= 1'b0;
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            byte_buf_q <= byte_buf_d;
            words_q    <= words_d;
            ovf_q      <= ovf_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    // Program memory is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign o_instr         = instr_q;
    assign o_pc_plus4      = pc_plus4_q;
    assign o_ifid_valid    = valid_q;
    assign o_state         = state_q;
    assign o_words_loaded  = words_q;
    assign o_load_overflow = ovf_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_load_valid = 1'b0;
    logic [7:0]    i_load_byte = 8'h0;
    logic          i_load_done = 1'b0;
    logic [31:0]   i_pc = 32'h0;
    logic          i_branch_taken = 1'b0;
    logic [31:0]   i_branch_target = 32'h0;
    logic          i_jump = 1'b0;
    logic [31:0]   i_jump_target = 32'h0;
    logic          i_stall = 1'b0;
    logic          i_flush = 1'b0;
    logic [31:0]   o_next_pc;
    logic          o_pc_stall;
    logic          o_halt;
    logic [31:0]   o_instr;
    logic [31:0]   o_pc_plus4;
    logic          o_ifid_valid;
    logic [1:0]    o_state;
    logic [AW:0]   o_words_loaded;
    logic          o_load_overflow;

    instr_fetch #(.MEM_DEPTH(DEPTH), .HALT_WORD(32'hFFFFFFFF)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_load_valid(i_load_valid), .i_load_byte(i_load_byte), .i_load_done(i_load_done),
        .i_pc(i_pc), .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_jump(i_jump), .i_jump_target(i_jump_target),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_next_pc(o_next_pc), .o_pc_stall(o_pc_stall), .o_halt(o_halt),
        .o_instr(o_instr), .o_pc_plus4(o_pc_plus4), .o_ifid_valid(o_ifid_valid),
        .o_state(o_state), .o_words_loaded(o_words_loaded), .o_load_overflow(o_load_overflow)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        i_load_valid = 1'b1;
        i_load_byte  = b;
        i_load_done  = done;
        tick();
        i_load_valid = 1'b0;
        i_load_done  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 3; k >= 0; k--) send_byte(tmp[8*k +: 8], 1'b0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        stall;
        logic        flush;
        logic [31:0] e_next_pc;
        logic        e_pc_stall;
        logic        e_halt;
        logic [31:0] e_instr;
        logic [31:0] e_p4;
        logic        e_valid;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[10];

    initial begin
        //            pc            br   brt          jmp  jt           st   fl   next_pc       pst  hlt  instr          p4            v    state
        vecs[0] = '{32'h0,        1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h4,        1'b0, 1'b0, 32'h20080005, 32'h4,        1'b1, 2'd1};
        vecs[1] = '{32'h4,        1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h8,        1'b0, 1'b0, 32'h11223344, 32'h8,        1'b1, 2'd1};
        vecs[2] = '{32'h8,        1'b1, 32'h20, 1'b0, 32'h0,  1'b0, 1'b0, 32'h20,       1'b0, 1'b0, 32'hAABBCCDD, 32'hC,        1'b1, 2'd1};
        vecs[3] = '{32'h4,        1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 1'b0, 32'h40,       1'b0, 1'b0, 32'h11223344, 32'h8,        1'b1, 2'd1};
        vecs[4] = '{32'h8,        1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'hC,        1'b1, 1'b0, 32'h11223344, 32'h8,        1'b1, 2'd1};
        vecs[5] = '{32'h4,        1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'h8,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 2'd1};
        vecs[6] = '{32'h10,       1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h14,       1'b0, 1'b0, 32'h0,        32'h14,       1'b1, 2'd1};
        vecs[7] = '{32'hFFFFFFFC, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 2'd1};
        vecs[8] = '{32'hC,        1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 2'd1};
        vecs[9] = '{32'hC,        1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h10,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 2'd1};

        // Reset values
        i_pc  = 32'h123;
        i_rst = 1'b1;
        #1;
        check("rst_comb_pc_stall", {31'b0, o_pc_stall}, 32'h1);
        check("rst_comb_halt",     {31'b0, o_halt},     32'h0);
        check("rst_comb_next_pc",  o_next_pc,           32'h123);
        tick(); tick();
        check("rst_state",    {30'b0, o_state},        32'h0);
        check("rst_instr",    o_instr,                 32'h0);
        check("rst_p4",       o_pc_plus4,              32'h0);
        check("rst_valid",    {31'b0, o_ifid_valid},   32'h0);
        check("rst_words",    {29'b0, o_words_loaded}, 32'h0);
        check("rst_ovf",      {31'b0, o_load_overflow},32'h0);
        i_rst = 1'b0;

        // Partial word, then reset: loading must restart at word 0
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        check("midload_rst_words", {29'b0, o_words_loaded}, 32'h0);
        check("load_pc_stall",     {31'b0, o_pc_stall},     32'h1);
        check("load_next_pc",      o_next_pc,               32'h123);
        send_word(32'h20080005);
        check("load_words_1",      {29'b0, o_words_loaded}, 32'h1);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        send_word(32'hFFFFFFFF);
        check("load_words_4",      {29'b0, o_words_loaded}, 32'h4);
        check("load_ovf_clear",    {31'b0, o_load_overflow},32'h0);
        check("load_state",        {30'b0, o_state},        32'h0);
        // Fifth word overflows; its last byte arrives together with done
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b1);
        check("ovf_words",  {29'b0, o_words_loaded},  32'h4);
        check("ovf_flag",   {31'b0, o_load_overflow}, 32'h1);
        check("run_state",  {30'b0, o_state},         32'h1);
        check("run_bubble", {31'b0, o_ifid_valid},    32'h0);

        // Table-driven RUN vectors
        for (int i = 0; i < 10; i++) begin
            i_pc = vecs[i].pc; i_branch_taken = vecs[i].br; i_branch_target = vecs[i].brt;
            i_jump = vecs[i].jmp; i_jump_target = vecs[i].jt;
            i_stall = vecs[i].stall; i_flush = vecs[i].flush;
            #1;
            check($sformatf("v%0d_next_pc", i),  o_next_pc,              vecs[i].e_next_pc);
            check($sformatf("v%0d_pc_stall", i), {31'b0, o_pc_stall},    {31'b0, vecs[i].e_pc_stall});
            check($sformatf("v%0d_halt", i),     {31'b0, o_halt},        {31'b0, vecs[i].e_halt});
            tick();
            check($sformatf("v%0d_instr", i),    o_instr,                vecs[i].e_instr);
            check($sformatf("v%0d_p4", i),       o_pc_plus4,             vecs[i].e_p4);
            check($sformatf("v%0d_valid", i),    {31'b0, o_ifid_valid},  {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_state", i),    {30'b0, o_state},       {30'b0, vecs[i].e_state});
        end

        // Halt word captured
        i_pc = 32'hC; i_stall = 1'b0; i_flush = 1'b0;
        i_jump = 1'b0; i_branch_taken = 1'b0;
        #1;
        check("halt_comb",    {31'b0, o_halt}, 32'h1);
        check("halt_next_pc", o_next_pc,       32'h10);
        tick();
        check("halt_instr",   o_instr,               32'hFFFFFFFF);
        check("halt_p4",      o_pc_plus4,            32'h10);
        check("halt_valid",   {31'b0, o_ifid_valid}, 32'h1);
        check("halt_state",   {30'b0, o_state},      32'h2);

        // HALTED: PC held, halt high, load traffic ignored, bubbles captured
        i_pc = 32'h20; i_jump = 1'b1; i_jump_target = 32'h40;
        i_load_valid = 1'b1; i_load_byte = 8'h12; i_load_done = 1'b1;
        #1;
        check("halted_next_pc",  o_next_pc,            32'h20);
        check("halted_halt",     {31'b0, o_halt},      32'h1);
        check("halted_pc_stall", {31'b0, o_pc_stall},  32'h0);
        tick();
        i_load_valid = 1'b0; i_load_done = 1'b0; i_jump = 1'b0;
        check("halted_valid",  {31'b0, o_ifid_valid},   32'h0);
        check("halted_state",  {30'b0, o_state},        32'h2);
        check("halted_words",  {29'b0, o_words_loaded}, 32'h4);

        // Reset keeps memory contents; overflow flag clears
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        check("rst2_state", {30'b0, o_state},         32'h0);
        check("rst2_ovf",   {31'b0, o_load_overflow}, 32'h0);
        i_load_done = 1'b1; tick(); i_load_done = 1'b0;
        check("rst2_run",   {30'b0, o_state},         32'h1);
        i_pc = 32'hC;
        #1;
        check("mem3_kept_halt", {31'b0, o_halt}, 32'h1);
        i_pc = 32'h0;
        tick();
        check("mem0_kept", o_instr, 32'h20080005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
